// File: rtl/sum_serial_pkg.sv
// ============================================================
// sum_serial_pkg: shared state encoding and digit-width helper
// Revision: 1.0
// ============================================================
`default_nettype none

package sum_serial_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_RUN   = 2'd1;
   localparam state_t ST_DRAIN = 2'd2;
   localparam state_t ST_DONE  = 2'd3;

   function automatic int digit_width(input int n, input int cc);
      return n / cc;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sum_serial_shreg.sv
// ============================================================
// sum_serial_shreg: parallel-load register that shifts right by one digit
// Revision: 1.0
// ============================================================
`default_nettype none

module sum_serial_shreg #(
   parameter int N     = 128,
   parameter int W     = 2,
   parameter int OUT_W = 128
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [N-1:0]     load_val,
   input  logic             shift,
   input  logic [W-1:0]     shift_in,
   output logic [OUT_W-1:0] q
);

   logic [N-1:0] sh_q;
   logic [N-1:0] sh_d;
   logic [N-1:0] w_shifted;

   // A single-digit register has no upper bits to slide down.
   if (N > W) begin : g_multi
      assign w_shifted = {shift_in, sh_q[N-1:W]};
   end else begin : g_single
      assign w_shifted = shift_in;
   end

   always_comb begin
      sh_d = sh_q;
      if (load) begin
         sh_d = load_val;
      end else if (shift) begin
         sh_d = w_shifted;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sh_q <= '0;
      end else begin
         sh_q <= sh_d;
      end
   end

   assign q = sh_q[OUT_W-1:0];

endmodule

`default_nettype wire

// File: rtl/sum_serial_ctrl.sv
// ============================================================
// sum_serial_ctrl: feeds N-bit operand pairs to a W-bit serial adder core
// and reassembles its registered digits into the sum. Revision: 1.0
// ============================================================
`default_nettype none

module sum_serial_ctrl
   import sum_serial_pkg::*;
#(
   parameter int N  = 128,
   parameter int CC = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N-1:0]      in_a,
   input  logic [N-1:0]      in_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [N-1:0]      out_sum,
   output logic              add_clr,
   output logic [N/CC-1:0]   add_a,
   output logic [N/CC-1:0]   add_b,
   input  logic [N/CC-1:0]   add_c,
   output logic              busy
);

   localparam int W     = digit_width(N, CC);
   localparam int IDX_W = (CC > 1) ? $clog2(CC) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CC - 1);

   if (N % CC != 0) begin : g_bad_params
      $error("sum_serial_ctrl: N must be a multiple of CC");
   end

   state_t           state_q;
   state_t           state_d;
   logic [IDX_W-1:0] idx_q;
   logic [IDX_W-1:0] idx_d;

   logic         w_accept;
   logic         w_run;
   logic         w_r_shift;
   logic [W-1:0] a_digit;
   logic [W-1:0] b_digit;
   logic [N-1:0] r_sh;

   assign w_accept  = in_valid && (state_q == ST_IDLE);
   assign w_run     = (state_q == ST_RUN);
   // The core's output lags by one cycle, so digit 0 only appears at idx 1.
   assign w_r_shift = (w_run && (idx_q != '0)) || (state_q == ST_DRAIN);

   sum_serial_shreg #(.N(N), .W(W), .OUT_W(W)) u_a_sh (
      .clk      (clk),
      .rst      (rst),
      .load     (w_accept),
      .load_val (in_a),
      .shift    (w_run),
      .shift_in ('0),
      .q        (a_digit)
   );

   sum_serial_shreg #(.N(N), .W(W), .OUT_W(W)) u_b_sh (
      .clk      (clk),
      .rst      (rst),
      .load     (w_accept),
      .load_val (in_b),
      .shift    (w_run),
      .shift_in ('0),
      .q        (b_digit)
   );

   sum_serial_shreg #(.N(N), .W(W), .OUT_W(N)) u_r_sh (
      .clk      (clk),
      .rst      (rst),
      .load     (1'b0),
      .load_val ('0),
      .shift    (w_r_shift),
      .shift_in (add_c),
      .q        (r_sh)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         ST_IDLE: begin
            if (w_accept) begin
               state_d = ST_RUN;
               idx_d   = '0;
            end
         end
         ST_RUN: begin
            if (idx_q == IDX_LAST) begin
               state_d = ST_DRAIN;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         ST_DRAIN: state_d = ST_DONE;
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Clearing in DONE as well keeps the core carry at zero between additions.
   assign in_ready  = (state_q == ST_IDLE);
   assign add_clr   = (state_q == ST_IDLE) || (state_q == ST_DONE);
   assign add_a     = w_run ? a_digit : '0;
   assign add_b     = w_run ? b_digit : '0;
   assign out_valid = (state_q == ST_DONE);
   assign out_sum   = r_sh;
   assign busy      = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_sum_serial_ctrl.sv
// ============================================================
// tb_sum_serial_ctrl: randomized and directed checks of the serial-add sequencer
// Revision: 1.0
// ============================================================
`default_nettype none

module tb_sum_serial_ctrl;

   localparam int N  = 128;
   localparam int CC = 64;
   localparam int W  = N / CC;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [N-1:0] in_a = '0;
   logic [N-1:0] in_b = '0;
   logic         in_ready;
   logic         out_valid;
   logic [N-1:0] out_sum;
   logic         add_clr;
   logic [W-1:0] add_a;
   logic [W-1:0] add_b;
   logic [W-1:0] add_c = '0;
   logic         busy;
   logic         core_carry = 1'b0;

   int       n_checks = 0;
   int       n_fail   = 0;
   bit [2:0] sweep_done = '0;

   always #5 clk = ~clk;

   sum_serial_ctrl #(.N(N), .CC(CC)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .add_clr   (add_clr),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_c     (add_c),
      .busy      (busy)
   );

   // Behavioural serial adder core: carry and registered digit cleared by add_clr.
   always @(posedge clk) begin
      if (add_clr) {core_carry, add_c} <= '0;
      else {core_carry, add_c} <= {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, core_carry};
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] digit(input logic [N-1:0] v, input int k);
      logic [N-1:0] t;
      t = v >> (W * k);
      return t[W-1:0];
   endfunction

   function automatic logic [N-1:0] rand_op();
      case ($urandom_range(0, 7))
         0:       return '1;
         1:       return '0;
         default: return {$urandom(), $urandom(), $urandom(), $urandom()};
      endcase
   endfunction

   // Reference model: a transaction is in flight for CC+1 cycles, then its sum waits for out_ready.
   bit           m_pending = 1'b0;
   int           m_cnt = 0;
   logic [N-1:0] m_a, m_b, m_sum;
   logic [W-1:0] m_ea, m_eb;
   bit           m_ev;

   always @(negedge clk) begin
      if (!rst) begin
         check("reset_ctrl", {add_a, add_b, in_ready, busy, out_valid, add_clr},
               {{(2*W){1'b0}}, 4'b1001});
         check("reset_sum", out_sum, '0);
         m_pending = 1'b0;
         m_cnt     = 0;
      end else begin
         m_ev = m_pending && (m_cnt >= CC + 1);
         m_ea = (m_pending && m_cnt < CC) ? digit(m_a, m_cnt) : '0;
         m_eb = (m_pending && m_cnt < CC) ? digit(m_b, m_cnt) : '0;
         check("cycle_ctrl", {add_a, add_b, in_ready, busy, out_valid, add_clr},
               {m_ea, m_eb, !m_pending, m_pending, m_ev, (!m_pending || m_ev)});
         if (m_ev) check("out_sum", out_sum, m_sum);
         if (!m_pending) begin
            if (in_valid) begin
               m_pending = 1'b1;
               m_cnt     = 0;
               m_a       = in_a;
               m_b       = in_b;
               m_sum     = in_a + in_b;
            end
         end else if (m_ev && out_ready) begin
            m_pending = 1'b0;
         end else begin
            m_cnt++;
         end
      end
   end

   // One handshaked addition; optional junk in_valid pulses and a stalled result.
   task automatic run_add(input logic [N-1:0] a, input logic [N-1:0] b, input bit junk,
                          input int hold, output logic [N-1:0] sum, output int lat,
                          output logic inr_after);
      int g;
      in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b0;
      g = 0;
      while (!in_ready && g < 200) begin
         @(posedge clk); #1; g++;
      end
      @(posedge clk); #1;
      lat = 0;
      in_valid = junk;
      in_a = ~a; in_b = a ^ b;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1; lat++;
         in_valid = junk && lat[0];
         in_a = rand_op(); in_b = rand_op();
      end
      for (int i = 0; i < hold; i++) begin
         in_valid = junk;
         @(posedge clk); #1;
      end
      sum = out_sum;
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      inr_after = in_ready;
      out_ready = 1'b0;
   endtask

   initial begin : p_main
      logic [N-1:0] s;
      int           lat, g, done_n, stall, cyc;
      logic         inr;

      repeat (3) @(posedge clk);
      #1;
      check("reset_in_ready_lit", in_ready, 1'b1);
      check("reset_add_clr_lit", add_clr, 1'b1);
      rst = 1'b1;
      @(posedge clk); #1;

      run_add(128'd3, 128'd5, 1'b0, 0, s, lat, inr);
      check("add_3_5", s, 128'd8);
      check("latency_3_5", lat, 65);
      check("in_ready_after_3_5", inr, 1'b1);

      run_add('1, 128'd1, 1'b0, 0, s, lat, inr);
      check("add_max_1", s, 128'd0);

      run_add({32{4'h5}}, {32{4'hA}}, 1'b0, 2, s, lat, inr);
      check("add_5s_as", s, {128{1'b1}});

      run_add(128'd100, 128'd23, 1'b1, 5, s, lat, inr);
      check("add_junk_ignored", s, 128'd123);

      done_n = 0; cyc = 0;
      stall = $urandom_range(0, 10);
      while (done_n < 1000 && cyc < 90000) begin
         @(posedge clk); #1; cyc++;
         in_valid = 1'b1;
         in_a = rand_op(); in_b = rand_op();
         if (out_valid) begin
            if (stall > 0) begin
               out_ready = 1'b0;
               stall--;
            end else begin
               out_ready = 1'b1;
               done_n++;
               stall = $urandom_range(0, 10);
            end
         end else begin
            out_ready = 1'($urandom_range(0, 1));
         end
      end
      check("random_results", done_n, 1000);
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      g = 0;
      while (busy && g < 200) begin
         @(posedge clk); #1; g++;
      end
      out_ready = 1'b0;

      in_a = '1; in_b = 128'd1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (30) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      check("async_reset_ctrl", {add_a, add_b, in_ready, busy, out_valid, add_clr},
            {{(2*W){1'b0}}, 4'b1001});
      check("async_reset_sum", out_sum, '0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      run_add(128'd7, 128'd9, 1'b0, 0, s, lat, inr);
      check("add_7_9_after_abort", s, 128'd16);
      check("latency_7_9", lat, 65);

      g = 0;
      while (sweep_done != 3'b111 && g < 500) begin
         @(posedge clk); g++;
      end
      check("sweep_complete", sweep_done, 3'b111);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
      localparam int SCC = (gi == 0) ? 1 : ((gi == 1) ? 4 : 8);
      localparam int SW  = 8 / SCC;

      logic          s_rst = 1'b0;
      logic          s_in_valid = 1'b0;
      logic          s_out_ready = 1'b1;
      logic [7:0]    s_in_a = '0;
      logic [7:0]    s_in_b = '0;
      logic          s_in_ready, s_out_valid, s_add_clr, s_busy;
      logic [7:0]    s_out_sum;
      logic [SW-1:0] s_add_a, s_add_b;
      logic [SW-1:0] s_add_c = '0;
      logic          s_carry = 1'b0;

      always @(posedge clk) begin
         if (s_add_clr) {s_carry, s_add_c} <= '0;
         else {s_carry, s_add_c} <= {1'b0, s_add_a} + {1'b0, s_add_b} + {{SW{1'b0}}, s_carry};
      end

      sum_serial_ctrl #(.N(8), .CC(SCC)) u_dut (
         .clk       (clk),
         .rst       (s_rst),
         .in_valid  (s_in_valid),
         .in_ready  (s_in_ready),
         .in_a      (s_in_a),
         .in_b      (s_in_b),
         .out_valid (s_out_valid),
         .out_ready (s_out_ready),
         .out_sum   (s_out_sum),
         .add_clr   (s_add_clr),
         .add_a     (s_add_a),
         .add_b     (s_add_b),
         .add_c     (s_add_c),
         .busy      (s_busy)
      );

      initial begin : p_run
         int lat;
         repeat (2) @(posedge clk);
         #1 s_rst = 1'b1;
         @(posedge clk); #1;
         for (int k = 0; k < 2; k++) begin
            s_in_a = (k == 0) ? 8'hFF : 8'h7F;
            s_in_b = 8'h01;
            s_in_valid = 1'b1;
            @(posedge clk); #1;
            s_in_valid = 1'b0;
            lat = 0;
            while (!s_out_valid && lat < 40) begin
               @(posedge clk); #1; lat++;
            end
            check($sformatf("sweep_cc%0d_sum_case%0d", SCC, k), s_out_sum,
                  (k == 0) ? 8'h00 : 8'h80);
            check($sformatf("sweep_cc%0d_latency_case%0d", SCC, k), lat, SCC + 1);
            @(posedge clk); #1;
         end
         sweep_done[gi] = 1'b1;
      end
   end

endmodule

`default_nettype wire
